// File: rtl/pc_pkg.sv
// Shared types and sizing for the packet collector: write/read FSM encodings
// and counter widths.
package pc_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_HOLD = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_EMPTY = 1'b0,
    R_READY = 1'b1
  } rd_state_t;

  localparam int CNT_W  = 8;
  localparam int BYTE_W = 8;

  // Idle counter width; a disabled timeout keeps a minimal 1-bit counter.
  function automatic int idle_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/packet_collector_bank.sv
// Two-bank packet RAM: one write port into the fill bank, one registered read
// port out of the drain bank.
module packet_bank
  import pc_pkg::*;
#(
  parameter int PACKET_LENGTH = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_bank,
  input  logic [CNT_W-1:0]  wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_bank,
  input  logic [CNT_W-1:0]  rd_addr,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data
);

  localparam int DEPTH = 2 * PACKET_LENGTH;
  localparam int AW    = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;

  function automatic logic [AW-1:0] flat_addr(input logic bank, input logic [CNT_W-1:0] addr);
    return bank ? (AW'(addr) + AW'(PACKET_LENGTH)) : AW'(addr);
  endfunction

  assign wr_idx = flat_addr(wr_bank, wr_addr);
  assign rd_idx = flat_addr(rd_bank, rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The read register is a module output, so it clears with reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/packet_collector.sv
// Receive-side packet assembler: groups byte strobes into fixed-length packets
// in a double-buffered RAM and serves them to a consumer one byte per cycle.
module packet_collector
  import pc_pkg::*;
#(
  parameter int PACKET_LENGTH = 20,
  parameter int TIMEOUT       = 1000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BYTE_W-1:0] Byte_In,
  input  logic              Byte_Valid,
  input  logic              Rd_En,
  output logic              Pkt_Ready,
  output logic [BYTE_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  output logic              Rd_Last,
  output logic [CNT_W-1:0]  Pkt_Count,
  output logic              Overrun,
  output logic              Timeout
);

  localparam int                IDLE_W     = idle_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(PACKET_LENGTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(PACKET_LENGTH);
  localparam logic [IDLE_W-1:0] IDLE_LIM   = IDLE_W'(TIMEOUT);
  localparam bit                TIMEOUT_EN = (TIMEOUT > 0);

  wr_state_t         wr_state, wr_state_n;
  rd_state_t         rd_state, rd_state_n;
  logic [CNT_W-1:0]  wr_cnt, wr_cnt_n;
  logic [CNT_W-1:0]  rd_ptr, rd_ptr_n;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
  logic [CNT_W-1:0]  pkt_count;
  logic              bv_q;
  logic              wr_sel;
  logic              rd_sel;
  logic              overrun_q, timeout_q, rd_valid_q, rd_last_q;

  logic              accept;
  logic              rd_fire;
  logic              rd_last_now;
  logic              bank_free;
  logic              timeout_hit;
  logic              swap;
  logic              wr_en;
  logic [CNT_W-1:0]  wr_addr;

  function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
    return (v == IDLE_LIM) ? v : v + IDLE_W'(1);
  endfunction

  assign accept      = Byte_Valid & ~bv_q;
  assign rd_fire     = (rd_state == R_READY) && Rd_En;
  assign rd_last_now = rd_fire && (rd_ptr == LAST_IDX);
  // The drain bank counts as free on the edge that reads its last byte.
  assign bank_free   = (rd_state == R_EMPTY) || rd_last_now;
  assign timeout_hit = TIMEOUT_EN && (wr_state == W_FILL) && (idle_cnt == IDLE_LIM);
  assign rd_sel      = ~wr_sel;

  always_comb begin
    wr_state_n = wr_state;
    wr_cnt_n   = wr_cnt;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt;
    swap       = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          wr_cnt_n   = CNT_W'(1);
          wr_state_n = W_FILL;
        end
      end
      W_FILL: begin
        if (timeout_hit) begin
          // Discard the stale partial; a byte arriving now opens a fresh packet.
          wr_cnt_n   = '0;
          wr_state_n = W_IDLE;
          if (accept) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_cnt_n   = CNT_W'(1);
            wr_state_n = W_FILL;
          end
        end else if (accept) begin
          wr_en = 1'b1;
          if (wr_cnt == LAST_IDX) begin
            if (bank_free) begin
              swap       = 1'b1;
              wr_cnt_n   = '0;
              wr_state_n = W_IDLE;
            end else begin
              wr_cnt_n   = FULL_CNT;
              wr_state_n = W_HOLD;
            end
          end else begin
            wr_cnt_n = wr_cnt + CNT_W'(1);
          end
        end
      end
      W_HOLD: begin
        if (rd_state == R_EMPTY) begin
          swap       = 1'b1;
          wr_cnt_n   = '0;
          wr_state_n = W_IDLE;
        end
      end
      default: begin
        wr_state_n = W_IDLE;
        wr_cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    rd_state_n = rd_state;
    rd_ptr_n   = rd_ptr;
    if (rd_fire) begin
      rd_ptr_n = rd_last_now ? '0 : rd_ptr + CNT_W'(1);
      if (rd_last_now) begin
        rd_state_n = R_EMPTY;
      end
    end
    if (swap) begin
      rd_state_n = R_READY;
    end
  end

  always_comb begin
    if (!TIMEOUT_EN || accept || (wr_state != W_FILL) || timeout_hit) begin
      idle_cnt_n = '0;
    end else begin
      idle_cnt_n = sat_inc(idle_cnt);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bv_q       <= 1'b0;
      wr_state   <= W_IDLE;
      rd_state   <= R_EMPTY;
      wr_cnt     <= '0;
      rd_ptr     <= '0;
      idle_cnt   <= '0;
      wr_sel     <= 1'b0;
      pkt_count  <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      bv_q       <= Byte_Valid;
      wr_state   <= wr_state_n;
      rd_state   <= rd_state_n;
      wr_cnt     <= wr_cnt_n;
      rd_ptr     <= rd_ptr_n;
      idle_cnt   <= idle_cnt_n;
      if (swap) begin
        wr_sel    <= ~wr_sel;
        pkt_count <= pkt_count + CNT_W'(1);
      end
      overrun_q  <= (wr_state == W_HOLD) && accept;
      timeout_q  <= timeout_hit;
      rd_valid_q <= rd_fire;
      rd_last_q  <= rd_last_now;
    end
  end

  packet_bank #(
    .PACKET_LENGTH(PACKET_LENGTH)
  ) u_bank (
    .clk     (Clk),
    .rst     (Rst),
    .wr_bank (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (Byte_In),
    .wr_en   (wr_en),
    .rd_bank (rd_sel),
    .rd_addr (rd_ptr),
    .rd_en   (rd_fire),
    .rd_data (Rd_Data)
  );

  assign Pkt_Ready = (rd_state == R_READY);
  assign Rd_Valid  = rd_valid_q;
  assign Rd_Last   = rd_last_q;
  assign Pkt_Count = pkt_count;
  assign Overrun   = overrun_q;
  assign Timeout   = timeout_q;

endmodule

// File: tb/tb_packet_collector.sv
// Directed-plus-random bench for packet_collector with a transaction-level
// reference model of the packet buffers, counters and status pulses.
module tb_packet_collector;

  localparam int PL = 20;
  localparam int TO = 1000;

  typedef logic [7:0] byte_t;

  logic       Clk;
  logic       Rst;
  logic [7:0] Byte_In;
  logic       Byte_Valid;
  logic       Rd_En;
  logic       Pkt_Ready;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic       Rd_Last;
  logic [7:0] Pkt_Count;
  logic       Overrun;
  logic       Timeout;

  packet_collector #(
    .PACKET_LENGTH(PL),
    .TIMEOUT(TO)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Byte_In    (Byte_In),
    .Byte_Valid (Byte_Valid),
    .Rd_En      (Rd_En),
    .Pkt_Ready  (Pkt_Ready),
    .Rd_Data    (Rd_Data),
    .Rd_Valid   (Rd_Valid),
    .Rd_Last    (Rd_Last),
    .Pkt_Count  (Pkt_Count),
    .Overrun    (Overrun),
    .Timeout    (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;
  int seen_ovr = 0;
  int seen_to  = 0;

  // Reference model: partial packet being filled, packet on the read side,
  // packet parked behind it, and the expected event totals.
  byte_t partial[$];
  byte_t rd_pkt[$];
  byte_t held[$];
  bit    rd_full   = 1'b0;
  bit    held_full = 1'b0;
  int    exp_count = 0;
  int    exp_ovr   = 0;
  int    exp_to    = 0;

  always @(negedge Clk) begin
    if (Overrun === 1'b1) seen_ovr <= seen_ovr + 1;
    if (Timeout === 1'b1) seen_to  <= seen_to + 1;
  end

  function automatic void model_reset();
    partial.delete();
    rd_pkt.delete();
    held.delete();
    rd_full   = 1'b0;
    held_full = 1'b0;
    exp_count = 0;
  endfunction

  function automatic void model_accept(input byte_t b);
    if (held_full) begin
      exp_ovr++;
    end else begin
      partial.push_back(b);
      if (partial.size() == PL) begin
        if (!rd_full) begin
          rd_pkt    = partial;
          rd_full   = 1'b1;
          exp_count = (exp_count + 1) % 256;
        end else begin
          held      = partial;
          held_full = 1'b1;
        end
        partial.delete();
      end
    end
  endfunction

  function automatic void model_read_done();
    rd_pkt.delete();
    rd_full = 1'b0;
    if (held_full) begin
      rd_pkt    = held;
      rd_full   = 1'b1;
      held.delete();
      held_full = 1'b0;
      exp_count = (exp_count + 1) % 256;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input byte_t b, input int hold);
    @(negedge Clk);
    Byte_In    = b;
    Byte_Valid = 1'b1;
    repeat (hold) @(negedge Clk);
    Byte_Valid = 1'b0;
    model_accept(b);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(byte_t'($urandom), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge Clk);
    if (partial.size() > 0 && n >= TO + 2) begin
      partial.delete();
      exp_to++;
    end
  endtask

  task automatic read_packet();
    byte_t exp[$];
    exp = rd_pkt;
    chk("ready_before_read", 32'(Pkt_Ready), 32'd1);
    @(negedge Clk);
    Rd_En = 1'b1;
    for (int i = 0; i < PL; i++) begin
      @(negedge Clk);
      chk("rd_valid", 32'(Rd_Valid), 32'd1);
      chk("rd_data", 32'(Rd_Data), 32'(exp[i]));
      chk("rd_last", 32'(Rd_Last), 32'(i == PL - 1));
    end
    Rd_En = 1'b0;
    chk("ready_drop", 32'(Pkt_Ready), 32'd0);
    @(negedge Clk);
    chk("rd_valid_idle", 32'(Rd_Valid), 32'd0);
    chk("ready_after_read", 32'(Pkt_Ready), 32'(held_full));
    model_read_done();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},   32'(Pkt_Ready), 32'd0);
    chk({tag, "_rdata"},   32'(Rd_Data),   32'd0);
    chk({tag, "_rvalid"},  32'(Rd_Valid),  32'd0);
    chk({tag, "_rlast"},   32'(Rd_Last),   32'd0);
    chk({tag, "_count"},   32'(Pkt_Count), 32'd0);
    chk({tag, "_overrun"}, 32'(Overrun),   32'd0);
    chk({tag, "_timeout"}, 32'(Timeout),   32'd0);
  endtask

  initial begin
    byte_t exp1[$];
    byte_t last_b;

    Rst        = 1'b1;
    Byte_In    = '0;
    Byte_Valid = 1'b0;
    Rd_En      = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;

    // Reads while empty are ignored
    @(negedge Clk);
    Rd_En = 1'b1;
    @(negedge Clk);
    Rd_En = 1'b0;
    chk("empty_rd_valid", 32'(Rd_Valid), 32'd0);
    chk("empty_ready", 32'(Pkt_Ready), 32'd0);

    // 1: counting bytes 0x00..0x13
    for (int i = 0; i < PL; i++) send_byte(byte_t'(i), 1);
    @(negedge Clk);
    chk("t1_ready", 32'(Pkt_Ready), 32'd1);
    chk("t1_count", 32'(Pkt_Count), 32'(exp_count));
    read_packet();
    chk("t1_count_after", 32'(Pkt_Count), 32'd1);

    // 2: long strobes count once each
    for (int i = 0; i < PL - 1; i++) send_byte(byte_t'($urandom), 5);
    repeat (2) @(negedge Clk);
    chk("t2_not_ready_19", 32'(Pkt_Ready), 32'd0);
    send_byte(byte_t'($urandom), 5);
    chk("t2_ready_20", 32'(Pkt_Ready), 32'd1);
    read_packet();
    chk("t2_count", 32'(Pkt_Count), 32'(exp_count));

    // 3: three packets unread -> one parked, third dropped byte by byte
    send_random(PL);
    send_random(PL);
    send_random(PL);
    repeat (3) @(negedge Clk);
    chk("t3_overruns", 32'(seen_ovr), 32'(exp_ovr));
    chk("t3_overrun_total", 32'(exp_ovr), 32'(PL));
    read_packet();
    read_packet();
    chk("t3_count", 32'(Pkt_Count), 32'(exp_count));
    chk("t3_ready_final", 32'(Pkt_Ready), 32'd0);

    // 4: stalled partial is discarded after the idle limit
    send_random(7);
    idle_wait(TO + 5);
    chk("t4_timeouts", 32'(seen_to), 32'(exp_to));
    chk("t4_timeout_total", 32'(exp_to), 32'd1);
    chk("t4_ready", 32'(Pkt_Ready), 32'd0);
    send_random(PL);
    @(negedge Clk);
    read_packet();
    chk("t4_count", 32'(Pkt_Count), 32'(exp_count));

    // 5: last read of packet 1 on the edge that completes packet 2
    send_random(PL);
    send_random(PL - 1);
    exp1   = rd_pkt;
    last_b = byte_t'($urandom);
    @(negedge Clk);
    Rd_En = 1'b1;
    for (int i = 0; i < PL; i++) begin
      @(negedge Clk);
      chk("t5_rd_data", 32'(Rd_Data), 32'(exp1[i]));
      chk("t5_rd_last", 32'(Rd_Last), 32'(i == PL - 1));
      chk("t5_ready_steady", 32'(Pkt_Ready), 32'd1);
      if (i == PL - 2) begin
        Byte_In    = last_b;
        Byte_Valid = 1'b1;
      end
    end
    Rd_En      = 1'b0;
    Byte_Valid = 1'b0;
    model_read_done();
    model_accept(last_b);
    @(negedge Clk);
    chk("t5_ready_kept", 32'(Pkt_Ready), 32'd1);
    chk("t5_overruns", 32'(seen_ovr), 32'(exp_ovr));
    read_packet();
    chk("t5_count", 32'(Pkt_Count), 32'(exp_count));

    // 6: reset mid-fill, then mid-read
    send_random(10);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check_all_zero("t6_fill");
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    send_random(PL);
    @(negedge Clk);
    Rd_En = 1'b1;
    repeat (5) @(negedge Clk);
    chk("t6_rd_valid_pre", 32'(Rd_Valid), 32'd1);
    Rst = 1'b1;
    #1;
    check_all_zero("t6_read");
    Rd_En = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    send_random(PL);
    @(negedge Clk);
    read_packet();
    chk("t6_count", 32'(Pkt_Count), 32'd1);
    chk("t6_overruns", 32'(seen_ovr), 32'(exp_ovr));
    chk("t6_timeouts", 32'(seen_to), 32'(exp_to));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
